// File: rtl/sub_top_conv.sv
// Convolution sub-top: shared IFM buffer, 16 weight buffers, 16 int8 MAC PEs.
// Build option OFM_RELU_EN: ReLU + unsigned saturation of the 8-bit outputs.
module sub_top_conv #(
   parameter int DATA_W    = 8,
   parameter int LANES     = 8,
   parameter int ADDR_W    = 7,
   parameter int ACC_W     = 32,
   parameter int NUM_PE    = 16,
   parameter int OUT_SHIFT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         addr,
   input  logic                      we,
   input  logic [DATA_W*LANES-1:0]   data_in_IFM,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_0,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_1,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_2,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_3,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_4,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_5,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_6,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_7,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_8,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_9,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_10,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_11,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_12,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_13,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_14,
   input  logic [DATA_W*LANES-1:0]   data_in_Weight_15,
   input  logic [19:0]               addr_w0,
   input  logic [19:0]               addr_w1,
   input  logic [19:0]               addr_w2,
   input  logic [19:0]               addr_w3,
   input  logic [19:0]               addr_w4,
   input  logic [19:0]               addr_w5,
   input  logic [19:0]               addr_w6,
   input  logic [19:0]               addr_w7,
   input  logic [19:0]               addr_w8,
   input  logic [19:0]               addr_w9,
   input  logic [19:0]               addr_w10,
   input  logic [19:0]               addr_w11,
   input  logic [19:0]               addr_w12,
   input  logic [19:0]               addr_w13,
   input  logic [19:0]               addr_w14,
   input  logic [19:0]               addr_w15,
   input  logic [NUM_PE-1:0]         PE_en,
   input  logic [NUM_PE-1:0]         PE_finish,
   output logic [ACC_W-1:0]          OFM,
   output logic [DATA_W-1:0]         OFM_0,
   output logic [DATA_W-1:0]         OFM_1,
   output logic [DATA_W-1:0]         OFM_2,
   output logic [DATA_W-1:0]         OFM_3,
   output logic [DATA_W-1:0]         OFM_4,
   output logic [DATA_W-1:0]         OFM_5,
   output logic [DATA_W-1:0]         OFM_6,
   output logic [DATA_W-1:0]         OFM_7,
   output logic [DATA_W-1:0]         OFM_8,
   output logic [DATA_W-1:0]         OFM_9,
   output logic [DATA_W-1:0]         OFM_10,
   output logic [DATA_W-1:0]         OFM_11,
   output logic [DATA_W-1:0]         OFM_12,
   output logic [DATA_W-1:0]         OFM_13,
   output logic [DATA_W-1:0]         OFM_14,
   output logic [DATA_W-1:0]         OFM_15
);

   localparam int WORD_W = DATA_W * LANES;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic [NUM_PE-1:0][WORD_W-1:0] wdata;
   logic [NUM_PE-1:0][19:0]       raddr;
   logic [NUM_PE-1:0][ACC_W-1:0]  acc_all;
   logic [NUM_PE-1:0][DATA_W-1:0] ofm_all;
   logic [NUM_PE-1:0]             unused_hi;

   assign wdata = {data_in_Weight_15, data_in_Weight_14, data_in_Weight_13,
                   data_in_Weight_12, data_in_Weight_11, data_in_Weight_10,
                   data_in_Weight_9,  data_in_Weight_8,  data_in_Weight_7,
                   data_in_Weight_6,  data_in_Weight_5,  data_in_Weight_4,
                   data_in_Weight_3,  data_in_Weight_2,  data_in_Weight_1,
                   data_in_Weight_0};
   assign raddr = {addr_w15, addr_w14, addr_w13, addr_w12,
                   addr_w11, addr_w10, addr_w9,  addr_w8,
                   addr_w7,  addr_w6,  addr_w5,  addr_w4,
                   addr_w3,  addr_w2,  addr_w1,  addr_w0};
   assign {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
           OFM_7,  OFM_6,  OFM_5,  OFM_4,  OFM_3,  OFM_2,  OFM_1, OFM_0} = ofm_all;
   assign OFM = acc_all[0];

   function automatic logic signed [ACC_W-1:0] dot8(
      input logic [WORD_W-1:0] a,
      input logic [WORD_W-1:0] b
   );
      logic signed [ACC_W-1:0]    s;
      logic signed [2*DATA_W-1:0] p;
      s = '0;
      for (int i = 0; i < LANES; i++) begin
         p = $signed(a[i*DATA_W +: DATA_W]) * $signed(b[i*DATA_W +: DATA_W]);
         s = s + ACC_W'(p);
      end
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] x);
      logic signed [ACC_W-1:0] y;
      y = x >>> OUT_SHIFT;
`ifdef OFM_RELU_EN
      if (y < 0)        return 8'h00;
      else if (y > 255) return 8'hFF;
      else              return y[DATA_W-1:0];
`else
      if (y < -128)     return 8'h80;
      else if (y > 127) return 8'h7F;
      else              return y[DATA_W-1:0];
`endif
   endfunction

   // Read-first buffers: same-cycle write and read return the old word.
   logic [WORD_W-1:0] ifm_mem [DEPTH];
   logic [WORD_W-1:0] ifm_q;

   always_ff @(posedge clk) begin
      if (we) ifm_mem[addr] <= data_in_IFM;
      ifm_q <= ifm_mem[addr];
   end

   logic [NUM_PE-1:0] en_q;
   logic [NUM_PE-1:0] fin_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q  <= '0;
         fin_q <= '0;
      end else begin
         en_q  <= PE_en;
         fin_q <= PE_finish;
      end
   end

   for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
      logic [WORD_W-1:0]       w_mem [DEPTH];
      logic [WORD_W-1:0]       w_q;
      logic signed [ACC_W-1:0] acc_q;
      logic signed [ACC_W-1:0] acc_d;
      logic signed [ACC_W-1:0] dot;
      logic signed [ACC_W-1:0] sum;
      logic [DATA_W-1:0]       ofm_q;
      logic [DATA_W-1:0]       ofm_d;

      always_ff @(posedge clk) begin
         if (we) w_mem[addr] <= wdata[k];
         w_q <= w_mem[raddr[k][ADDR_W-1:0]];
      end

      always_comb begin
         dot   = dot8(ifm_q, w_q);
         sum   = acc_q + (en_q[k] ? dot : {ACC_W{1'b0}});
         acc_d = acc_q;
         ofm_d = ofm_q;
         if (fin_q[k]) begin
            acc_d = '0;
            ofm_d = quant(sum);
         end else if (en_q[k]) begin
            acc_d = sum;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            acc_q <= '0;
            ofm_q <= '0;
         end else begin
            acc_q <= acc_d;
            ofm_q <= ofm_d;
         end
      end

      assign acc_all[k]   = acc_q;
      assign ofm_all[k]   = ofm_q;
      assign unused_hi[k] = ^raddr[k][19:ADDR_W];
   end

endmodule

// File: tb/tb_sub_top_conv.sv
// Randomized bench for sub_top_conv against a transaction-level reference.
// Expectations follow OFM_RELU_EN when the bench is built with it.
module tb_sub_top_conv;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  addr;
   logic        we;
   logic [63:0] ifm_d;
   logic [63:0] wd [16];
   logic [19:0] aw [16];
   logic [15:0] pe_en;
   logic [15:0] pe_fin;
   logic [31:0] ofm;
   logic [7:0]  ofm_k [16];

   int checks = 0;
   int fails  = 0;

   // Reference state: buffers, accumulators, outputs, and the
   // enable/finish/dot captured at the previous edge.
   logic [63:0] m_ifm [128];
   logic [63:0] m_w [16][128];
   int          m_acc [16];
   logic [7:0]  m_ofm [16];
   logic        p_en [16];
   logic        p_fin [16];
   int          p_dot [16];

   always #5 clk = ~clk;

   sub_top_conv dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we),
      .data_in_IFM(ifm_d),
      .data_in_Weight_0(wd[0]),   .data_in_Weight_1(wd[1]),
      .data_in_Weight_2(wd[2]),   .data_in_Weight_3(wd[3]),
      .data_in_Weight_4(wd[4]),   .data_in_Weight_5(wd[5]),
      .data_in_Weight_6(wd[6]),   .data_in_Weight_7(wd[7]),
      .data_in_Weight_8(wd[8]),   .data_in_Weight_9(wd[9]),
      .data_in_Weight_10(wd[10]), .data_in_Weight_11(wd[11]),
      .data_in_Weight_12(wd[12]), .data_in_Weight_13(wd[13]),
      .data_in_Weight_14(wd[14]), .data_in_Weight_15(wd[15]),
      .addr_w0(aw[0]),   .addr_w1(aw[1]),   .addr_w2(aw[2]),
      .addr_w3(aw[3]),   .addr_w4(aw[4]),   .addr_w5(aw[5]),
      .addr_w6(aw[6]),   .addr_w7(aw[7]),   .addr_w8(aw[8]),
      .addr_w9(aw[9]),   .addr_w10(aw[10]), .addr_w11(aw[11]),
      .addr_w12(aw[12]), .addr_w13(aw[13]), .addr_w14(aw[14]),
      .addr_w15(aw[15]),
      .PE_en(pe_en), .PE_finish(pe_fin), .OFM(ofm),
      .OFM_0(ofm_k[0]),   .OFM_1(ofm_k[1]),   .OFM_2(ofm_k[2]),
      .OFM_3(ofm_k[3]),   .OFM_4(ofm_k[4]),   .OFM_5(ofm_k[5]),
      .OFM_6(ofm_k[6]),   .OFM_7(ofm_k[7]),   .OFM_8(ofm_k[8]),
      .OFM_9(ofm_k[9]),   .OFM_10(ofm_k[10]), .OFM_11(ofm_k[11]),
      .OFM_12(ofm_k[12]), .OFM_13(ofm_k[13]), .OFM_14(ofm_k[14]),
      .OFM_15(ofm_k[15])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int ref_dot(input logic [63:0] a, input logic [63:0] b);
      int s = 0;
      for (int i = 0; i < 8; i++)
         s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
      return s;
   endfunction

   function automatic logic [7:0] ref_quant(input int x);
      int y = x >>> 8;
`ifdef OFM_RELU_EN
      if (y < 0) y = 0;
      if (y > 255) y = 255;
`else
      if (y < -128) y = -128;
      if (y > 127) y = 127;
`endif
      return y[7:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         m_acc[k] = 0;
         m_ofm[k] = 8'h00;
         p_en[k]  = 1'b0;
         p_fin[k] = 1'b0;
         p_dot[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 16; k++) begin
         if (p_fin[k]) begin
            m_ofm[k] = ref_quant(m_acc[k] + (p_en[k] ? p_dot[k] : 0));
            m_acc[k] = 0;
         end else if (p_en[k]) begin
            m_acc[k] += p_dot[k];
         end
      end
      for (int k = 0; k < 16; k++) begin
         p_en[k]  = pe_en[k];
         p_fin[k] = pe_fin[k];
         p_dot[k] = ref_dot(m_ifm[addr], m_w[k][aw[k][6:0]]);
      end
   endtask

   task automatic check_all();
      check("OFM", ofm, m_acc[0]);
      for (int k = 0; k < 16; k++)
         check($sformatf("OFM_%0d", k), {24'h0, ofm_k[k]}, {24'h0, m_ofm[k]});
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      if (we) begin
         m_ifm[addr] = ifm_d;
         for (int k = 0; k < 16; k++) m_w[k][addr] = wd[k];
      end
      #1;
      check_all();
   endtask

   task automatic idle();
      we     = 1'b0;
      pe_en  = '0;
      pe_fin = '0;
   endtask

   task automatic rand_inputs();
      we     = ($urandom_range(0, 5) == 0);
      addr   = 7'($urandom_range(0, 15));
      ifm_d  = {$urandom, $urandom};
      pe_en  = 16'($urandom);
      pe_fin = 16'($urandom & $urandom & $urandom);
      for (int k = 0; k < 16; k++) begin
         wd[k] = {$urandom, $urandom};
         aw[k] = {13'($urandom), 7'($urandom_range(0, 15))};
      end
   endtask

   initial begin
      reset = 1'b1;
      addr  = '0;
      ifm_d = '0;
      for (int k = 0; k < 16; k++) begin
         wd[k] = '0;
         aw[k] = '0;
      end
      idle();
      model_reset();
      step();
      step();
      reset = 1'b0;
      step();

      // Fill every buffer word so the model and DUT start from known data.
      for (int a = 0; a < 128; a++) begin
         we    = 1'b1;
         addr  = 7'(a);
         ifm_d = {$urandom, $urandom};
         for (int k = 0; k < 16; k++) wd[k] = {$urandom, $urandom};
         step();
      end
      idle();

      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         step();
      end

      // Reset in the middle of an all-PE accumulation.
      idle();
      pe_en = 16'hFFFF;
      for (int n = 0; n < 3; n++) step();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_OFM", ofm, 32'd0);
      for (int k = 0; k < 16; k++)
         check($sformatf("rst_OFM_%0d", k), {24'h0, ofm_k[k]}, 32'h0);
      step();
      idle();
      reset = 1'b0;
      pe_fin = 16'h0008;
      step();
      pe_fin = '0;
      step();
      check("pe3_noen", {24'h0, ofm_k[3]}, 32'h00);

      // PE0: one MAC of 0x10 lanes, then finish.
      we = 1'b1; addr = 7'd0;
      ifm_d = 64'h1010101010101010;
      wd[0] = 64'h1010101010101010;
      step();
      idle(); aw[0] = 20'd0; pe_en = 16'h0001;
      step();
      pe_en = '0; pe_fin = 16'h0001;
      step();
      check("pe0_acc", ofm, 32'd2048);
      pe_fin = '0;
      step();
      check("pe0_ofm", {24'h0, ofm_k[0]}, 32'h08);
      check("pe0_clr", ofm, 32'd0);

      // PE1: negative weights.
      we = 1'b1; addr = 7'd5;
      ifm_d = 64'h1010101010101010;
      wd[1] = 64'hF0F0F0F0F0F0F0F0;
      step();
      idle(); aw[1] = 20'd5; pe_en = 16'h0002;
      step();
      pe_en = '0; pe_fin = 16'h0002;
      step();
      pe_fin = '0;
      step();
`ifdef OFM_RELU_EN
      check("pe1_neg", {24'h0, ofm_k[1]}, 32'h00);
`else
      check("pe1_neg", {24'h0, ofm_k[1]}, 32'hF8);
`endif

      // PE2: four max-positive MACs saturate.
      we = 1'b1; addr = 7'd9;
      ifm_d = 64'h7F7F7F7F7F7F7F7F;
      wd[2] = 64'h7F7F7F7F7F7F7F7F;
      step();
      idle(); aw[2] = 20'd9; pe_en = 16'h0004;
      for (int n = 0; n < 4; n++) step();
      pe_en = '0; pe_fin = 16'h0004;
      step();
      pe_fin = '0;
      step();
`ifdef OFM_RELU_EN
      check("pe2_sat", {24'h0, ofm_k[2]}, 32'hFF);
`else
      check("pe2_sat", {24'h0, ofm_k[2]}, 32'h7F);
`endif

      // PE0 and PE1 together; all other outputs must stay cleared.
      reset = 1'b1;
      model_reset();
      step();
      reset = 1'b0;
      we = 1'b1; addr = 7'd12;
      ifm_d = 64'h2020202020202020;
      wd[0] = 64'h2020202020202020;
      wd[1] = 64'h1010101010101010;
      step();
      idle(); aw[0] = 20'd12; aw[1] = 20'hABC0C; pe_en = 16'h0003;
      step();
      pe_en = '0; pe_fin = 16'h0003;
      step();
      pe_fin = '0;
      step();
      check("pair_0", {24'h0, ofm_k[0]}, 32'h20);
      check("pair_1", {24'h0, ofm_k[1]}, 32'h10);
      for (int k = 2; k < 16; k++)
         check($sformatf("pair_idle_%0d", k), {24'h0, ofm_k[k]}, 32'h0);

      // PE0 enable and finish in the same cycle.
      addr = 7'd0; aw[0] = 20'd0; pe_en = 16'h0001;
      step();
      pe_fin = 16'h0001;
      step();
      check("same_acc", ofm, 32'd2048);
      idle();
      step();
      check("same_ofm", {24'h0, ofm_k[0]}, 32'h10);
      check("same_clr", ofm, 32'd0);

      for (int n = 0; n < 200; n++) begin
         rand_inputs();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/sub_top_conv.md
Name: sub_top_conv

Overview:
Convolution sub-top containing one shared IFM buffer, sixteen per-PE weight buffers and sixteen 8-lane int8 MAC processing elements (PEs). A host loads IFM and weight words through a common write port. Each PE then multiplies the IFM word at `addr` by its own weight word at `addr_wk`, accumulates into 32 bits, and on finish emits a requantized 8-bit output. It sits between the feature/weight loader and the OFM writer.

Parameters:
- DATA_W, 8: element width in bits (signed int8).
- LANES, 8: elements per 64-bit word.
- ADDR_W, 7: buffer depth is 2^ADDR_W = 128 words.
- ACC_W, 32: accumulator width.
- NUM_PE, 16: number of PEs and weight buffers.
- OUT_SHIFT, 8: right shift applied before 8-bit saturation.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- addr  in  7  shared write address; also the IFM read address.
- we  in  1  write enable for the IFM buffer and all 16 weight buffers.
- data_in_IFM  in  64  IFM write word.
- data_in_Weight_0..data_in_Weight_15  in  64 each  weight write word for PE k.
- addr_w0..addr_w15  in  20 each  weight read address for PE k; only bits [6:0] are used.
- PE_en  in  16  bit k enables a MAC in PE k.
- PE_finish  in  16  bit k closes the accumulation of PE k.
- OFM  out  32  raw accumulator of PE0.
- OFM_0..OFM_15  out  8 each  requantized result of PE k.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-high.
- Writes are synchronous. When we=1, IFM_mem[addr]<=data_in_IFM and Wk_mem[addr]<=data_in_Weight_k for all k in the same cycle.
- Reads are synchronous with 1-cycle latency. ifm_q<=IFM_mem[addr]; wk_q<=Wk_mem[addr_wk[6:0]]. Reads are read-first: a read of an address written in the same cycle returns the old data.
- Buffer contents are not cleared by reset.
- PE_en and PE_finish are registered once (en_d, fin_d) so they align with the read data.
- Word layout: lane i occupies bits [8i+7:8i]. Lanes are signed two's complement.
- dot = sum over 8 lanes of ifm_q lane × wk_q lane, with signed 16-bit products. dot is sign-extended to ACC_W.
- PE k, each cycle:
  - en_d=1, fin_d=0: acc<=acc+dot. Addition wraps modulo 2^32.
  - fin_d=1: final=acc+(en_d?dot:0); OFM_k<=quant(final); acc<=0.
  - otherwise: acc holds.
- OFM_k is held until the next finish or reset.
- quant(x): y=x>>>OUT_SHIFT (arithmetic shift), then saturated per the Optional Feature.
- OFM is a combinational copy of PE0's acc register. It therefore reads 0 in the cycle after a PE0 finish.
- Latency: a PE_en asserted in cycle n updates acc at the edge ending cycle n+1. A PE_finish asserted in cycle n updates OFM_k at the edge ending cycle n+1.
- PEs are fully independent. Any subset may be active at once.
- Reset, including mid-accumulation: all acc=0, all OFM_k=0, OFM=0, en_d=fin_d=0.
- A finish with no prior enable yields quant(0)=0.

Optional Feature:
- Macro: OFM_RELU_EN.
- Defined: ReLU plus unsigned saturation. y<0 gives 0x00; y>255 gives 0xFF; otherwise y[7:0].
- Not defined: signed saturation to [-128,127], output as two's complement.

Test Plan:
- Reset asserted mid-run with PE_en=0xFFFF → all OFM_k=0x00 and OFM=0. After release, finish on PE3 without any enable → OFM_3=0x00.
- Write IFM[0]=0x1010101010101010 and W0[0]=0x1010101010101010. Then addr=0, addr_w0=0, PE_en[0]=1 for 1 cycle, next cycle PE_finish[0]=1 → OFM=2048 before the finish edge, OFM_0=0x08, then OFM=0.
- Same IFM word with W1[5]=0xF0F0F0F0F0F0F0F0, addr_w1=5, en then finish on PE1 → with OFM_RELU_EN OFM_0... OFM_1=0x00; without it OFM_1=0xF8.
- IFM and W2 all bytes 0x7F, PE_en[2]=1 for 4 cycles, then finish → acc=516128 → OFM_2=0xFF with OFM_RELU_EN, 0x7F without.
- PE_en=0x0003 and PE_finish=0x0003 with distinct W0/W1 contents → OFM_0 and OFM_1 differ as computed; OFM_2..OFM_15 remain 0.
- Same-cycle en and finish on PE0 with acc=2048 and dot=2048 → OFM_0=0x10 and acc=0.
